// File: rtl/vga_sync_if.sv
// Video input bus from a VGA timing source: active-low syncs plus 3-3-2 RGB.
`timescale 1ns/1ps
interface vga_sync_if;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;

  modport master (output hsync, vsync, red, green, blue);
  modport slave  (input  hsync, vsync, red, green, blue);
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sink: recovers position from hsync/vsync, checks line/frame timing against nominal,
// locks after consecutive good frames and then streams active pixels with coordinates.
`timescale 1ns/1ps
module vga_sync_receiver #(
  parameter int HPIXELS     = 800,
  parameter int VLINES      = 521,
  parameter int HPULSE      = 96,
  parameter int VPULSE      = 2,
  parameter int HBP         = 144,
  parameter int HFP         = 784,
  parameter int VBP         = 31,
  parameter int VFP         = 511,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       dclk,
  input  logic       clr,
  vga_sync_if.slave  vid,
  output logic       px_valid,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic [7:0] px_data,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       err,
  output logic [7:0] err_count
);

  localparam int GW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state_q, state_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic            frame_bad_q, frame_bad_d;
  logic            s1_hs_q, s1_hs_d;
  logic [7:0]      s1_rgb_q, s1_rgb_d;
  logic [9:0]      rx_hc_q, rx_hc_d;
  logic [9:0]      rx_vc_q, rx_vc_d;
  logic            vs_line_q, vs_line_d;
  logic [9:0]      line_len_q, line_len_d;
  logic [9:0]      frame_lines_q, frame_lines_d;
  logic            err_q, err_d;
  logic [7:0]      err_count_q, err_count_d;
  logic            locked_q, locked_d;
  logic            px_valid_q, px_valid_d;
  logic [9:0]      px_x_q, px_x_d;
  logic [9:0]      px_y_q, px_y_d;
  logic [7:0]      px_data_q, px_data_d;

  logic            hs_fall, hs_rise, vs_fall, vs_end;
  logic [10:0]     hc_p1, vc_p1;
  logic            any_fail, watchdog;

  // Edge detection compares the raw input against the s1 copy, so rx_hc tracks s1.
  always_comb begin
    hs_fall  = s1_hs_q && !vid.hsync;
    hs_rise  = !s1_hs_q && vid.hsync;
    vs_fall  = hs_fall && !vid.vsync && vs_line_q;
    vs_end   = hs_fall && vid.vsync && !vs_line_q;
    hc_p1    = {1'b0, rx_hc_q} + 11'd1;
    vc_p1    = {1'b0, rx_vc_q} + 11'd1;
    any_fail = (hs_fall && (hc_p1 != 11'(HPIXELS)))
             | (hs_rise && (hc_p1 != 11'(HPULSE)))
             | (vs_end  && (vc_p1 != 11'(VPULSE)))
             | (vs_fall && (vc_p1 != 11'(VLINES)));
    watchdog = (rx_hc_q == 10'h3FF) || (rx_vc_q == 10'h3FF);
  end

  always_comb begin
    s1_hs_d       = vid.hsync;
    s1_rgb_d      = {vid.red, vid.green, vid.blue};
    rx_hc_d       = hs_fall ? 10'd0 : sat_inc10(rx_hc_q);
    rx_vc_d       = rx_vc_q;
    vs_line_d     = vs_line_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    if (hs_fall) begin
      rx_vc_d    = vs_fall ? 10'd0 : sat_inc10(rx_vc_q);
      vs_line_d  = vid.vsync;
      line_len_d = hc_p1[9:0];
    end
    if (vs_fall) frame_lines_d = vc_p1[9:0];
  end

  // Lock FSM; the watchdog overrides everything and only reports when it breaks a lock.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    frame_bad_d = frame_bad_q | any_fail;
    err_d       = 1'b0;
    if (watchdog) begin
      state_d    = SEARCH;
      good_cnt_d = '0;
      err_d      = (state_q == LOCKED);
    end else begin
      case (state_q)
        SEARCH: begin
          if (vs_fall) begin
            state_d     = MEASURE;
            good_cnt_d  = '0;
            frame_bad_d = 1'b0;
          end
        end
        MEASURE: begin
          if (vs_fall) begin
            frame_bad_d = 1'b0;
            if (!frame_bad_q && !any_fail) begin
              good_cnt_d = good_cnt_q + GW'(1);
              if (good_cnt_d == GW'(LOCK_FRAMES)) state_d = LOCKED;
            end else begin
              good_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (vs_fall) frame_bad_d = 1'b0;
          if (any_fail) begin
            err_d      = 1'b1;
            state_d    = MEASURE;
            good_cnt_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    err_count_d = err_d ? sat_inc8(err_count_q) : err_count_q;
    locked_d    = (state_d == LOCKED);
  end

  always_comb begin
    px_valid_d = (state_q == LOCKED)
              && (rx_hc_q >= 10'(HBP)) && (rx_hc_q < 10'(HFP))
              && (rx_vc_q >= 10'(VBP)) && (rx_vc_q < 10'(VFP));
    px_x_d     = px_x_q;
    px_y_d     = px_y_q;
    px_data_d  = px_data_q;
    if (px_valid_d) begin
      px_x_d    = rx_hc_q - 10'(HBP);
      px_y_d    = rx_vc_q - 10'(VBP);
      px_data_d = s1_rgb_q;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q       <= SEARCH;
      good_cnt_q    <= '0;
      frame_bad_q   <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_rgb_q      <= '0;
      rx_hc_q       <= '0;
      rx_vc_q       <= '0;
      vs_line_q     <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      locked_q      <= 1'b0;
      px_valid_q    <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      px_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      frame_bad_q   <= frame_bad_d;
      s1_hs_q       <= s1_hs_d;
      s1_rgb_q      <= s1_rgb_d;
      rx_hc_q       <= rx_hc_d;
      rx_vc_q       <= rx_vc_d;
      vs_line_q     <= vs_line_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
      locked_q      <= locked_d;
      px_valid_q    <= px_valid_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      px_data_q     <= px_data_d;
    end
  end

  assign px_valid    = px_valid_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_data     = px_data_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err         = err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: a scaled-down timing generator drives the receiver through
// lock, pixel streaming, timing faults, watchdog and mid-frame reset.
`timescale 1ns/1ps
module tb_vga_sync_receiver;
  localparam int HP   = 40;
  localparam int HPUL = 4;
  localparam int HBPP = 8;
  localparam int HFPP = 36;
  localparam int VL   = 20;
  localparam int VPUL = 2;
  localparam int VBPP = 4;
  localparam int VFPP = 16;
  localparam int PW   = HFPP - HBPP;
  localparam int PH   = VFPP - VBPP;

  logic dclk = 1'b0;
  logic clr  = 1'b1;
  always #5 dclk = ~dclk;

  vga_sync_if vif();

  logic       px_valid, locked, err;
  logic [9:0] px_x, px_y, line_len, frame_lines;
  logic [7:0] px_data, err_count;

  vga_sync_receiver #(
    .HPIXELS(HP), .VLINES(VL), .HPULSE(HPUL), .VPULSE(VPUL),
    .HBP(HBPP), .HFP(HFPP), .VBP(VBPP), .VFP(VFPP), .LOCK_FRAMES(2)
  ) dut (
    .dclk(dclk), .clr(clr), .vid(vif),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines),
    .err(err), .err_count(err_count)
  );

  int unsigned cyc = 0;
  always @(posedge dclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [27:0] pix;
    int unsigned due;
  } exp_t;
  exp_t sb_q[$];

  int  gen_hc = 0, gen_vc = 0;
  int  short_vc = -1, hp_short_vc = -1;
  bit  hs_stuck = 1'b0, vs_long = 1'b0, sb_on = 1'b0;
  int  px_cnt = 0, err_seen = 0;
  logic [27:0] first_pix = '0, last_pix = '0;

  function automatic logic [7:0] colr(input int h, input int v);
    return 8'(h * 5 + v);
  endfunction

  // One generator clock: drive the current position, let the DUT sample it, advance.
  task automatic step();
    logic [7:0] c;
    int hs_thr, vs_thr;
    exp_t e;
    c      = colr(gen_hc, gen_vc);
    hs_thr = (gen_vc == hp_short_vc) ? HPUL - 1 : HPUL;
    vs_thr = vs_long ? VPUL + 1 : VPUL;
    vif.hsync = hs_stuck || (gen_hc >= hs_thr);
    vif.vsync = (gen_vc >= vs_thr);
    vif.red   = c[7:5];
    vif.green = c[4:2];
    vif.blue  = c[1:0];
    if (sb_on && gen_hc >= HBPP && gen_hc < HFPP && gen_vc >= VBPP && gen_vc < VFPP) begin
      e.pix = {10'(gen_hc - HBPP), 10'(gen_vc - VBPP), c};
      e.due = cyc + 2;
      sb_q.push_back(e);
    end
    @(posedge dclk);
    #1;
    if (gen_hc == HP - 1 || (gen_vc == short_vc && gen_hc == HP - 2)) begin
      gen_hc = 0;
      gen_vc = (gen_vc == VL - 1) ? 0 : gen_vc + 1;
    end else begin
      gen_hc = gen_hc + 1;
    end
  endtask

  task automatic to_line(input int v);
    while (!(gen_hc == 0 && gen_vc == v)) step();
  endtask

  // Three frame starts: enter MEASURE / first good frame / second good frame -> lock.
  task automatic relock_check(input string tag);
    to_line(0); step(); check_val({tag, "_lock_f1"}, locked, 0);
    to_line(0); step(); check_val({tag, "_lock_f2"}, locked, 0);
    check_val({tag, "_frame_lines"}, frame_lines, VL);
    to_line(0);
    check_val({tag, "_lock_pre"}, locked, 0);
    step();
    check_val({tag, "_lock_f3"}, locked, 1);
  endtask

  initial begin
    forever begin
      @(negedge dclk);
      if (err === 1'b1) err_seen++;
      if (sb_on && px_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_val("px_extra", sb_q.size(), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_val("px_pix", {px_x, px_y, px_data}, e.pix);
          check_val("px_latency", cyc, e.due);
          if (px_cnt == 0) first_pix = {px_x, px_y, px_data};
          last_pix = {px_x, px_y, px_data};
          px_cnt++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    vif.hsync = 1'b1; vif.vsync = 1'b1;
    vif.red = '0; vif.green = '0; vif.blue = '0;
    clr = 1'b1;
    gen_hc = 0; gen_vc = VL - 4;
    repeat (3) step();
    check_val("rst_locked", locked, 0);
    check_val("rst_px_valid", px_valid, 0);
    check_val("rst_err", err, 0);
    check_val("rst_err_count", err_count, 0);
    check_val("rst_line_len", line_len, 0);
    check_val("rst_frame_lines", frame_lines, 0);
    clr = 1'b0;

    relock_check("s1");
    check_val("s1_line_len", line_len, HP);

    // Full locked frame through the scoreboard
    px_cnt = 0;
    sb_on  = 1'b1;
    to_line(0);
    sb_on  = 1'b0;
    check_val("s2_px_count", px_cnt, PW * PH);
    check_val("s2_sb_left", sb_q.size(), 0);
    check_val("s2_first_px", first_pix, {10'd0, 10'd0, colr(HBPP, VBPP)});
    check_val("s2_last_px", last_pix, {10'(PW - 1), 10'(PH - 1), colr(HFPP - 1, VFPP - 1)});
    check_val("s2_hold_valid", px_valid, 0);
    check_val("s2_hold_xy", {px_x, px_y}, {10'(PW - 1), 10'(PH - 1)});
    check_val("s2_err_count", err_count, 0);
    check_val("s2_err_seen", err_seen, 0);
    check_val("s2_locked", locked, 1);

    // Short line
    e0 = err_seen;
    to_line(5);
    short_vc = 5;
    to_line(6);
    short_vc = -1;
    step();
    check_val("s3_err", err, 1);
    check_val("s3_locked", locked, 0);
    check_val("s3_line_len", line_len, HP - 1);
    check_val("s3_err_count", err_count, 1);
    step();
    check_val("s3_err_off", err, 0);
    relock_check("s3");
    check_val("s3_err_pulses", err_seen - e0, 1);

    // Short hsync pulse
    to_line(6);
    hp_short_vc = 6;
    while (gen_hc != HPUL - 1) step();
    step();
    check_val("s4a_err", err, 1);
    check_val("s4a_locked", locked, 0);
    check_val("s4a_err_count", err_count, 2);
    hp_short_vc = -1;
    relock_check("s4a");

    // Long vsync pulse
    to_line(0);
    vs_long = 1'b1;
    to_line(VPUL + 1);
    step();
    check_val("s4b_err", err, 1);
    check_val("s4b_locked", locked, 0);
    check_val("s4b_err_count", err_count, 3);
    vs_long = 1'b0;
    relock_check("s4b");

    // Stuck hsync -> watchdog
    e0 = err_seen;
    to_line(5);
    step();
    for (int n = 1; n <= 1023; n++) begin
      if (gen_hc == HPUL + 1) hs_stuck = 1'b1;
      step();
    end
    check_val("s5_locked_pre", locked, 1);
    check_val("s5_err_pre", err, 0);
    step();
    check_val("s5_err", err, 1);
    check_val("s5_locked", locked, 0);
    check_val("s5_err_count", err_count, 4);
    step();
    check_val("s5_err_off", err, 0);
    to_line(8);
    hs_stuck = 1'b0;
    relock_check("s5");
    check_val("s5_err_pulses", err_seen - e0, 1);

    // Asynchronous clear in the middle of the active area
    to_line(VBPP + 3);
    while (gen_hc != HBPP + 5) step();
    step();
    check_val("s6_px_valid_pre", px_valid, 1);
    #1 clr = 1'b1;
    #1;
    check_val("s6_px_valid", px_valid, 0);
    check_val("s6_locked", locked, 0);
    check_val("s6_err_count", err_count, 0);
    check_val("s6_line_len", line_len, 0);
    check_val("s6_frame_lines", frame_lines, 0);
    repeat (3) step();
    clr = 1'b0;
    relock_check("s6");
    check_val("s6_line_len_end", line_len, HP);
    check_val("s6_err_count_end", err_count, 0);
    check_val("all_err_pulses", err_seen, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
